region_mpu: RTL

REGION_MPU -- requirements
Module: region_mpu

---
 rtl/mpu_pkg.sv | 41 ++++
 rtl/region_match.sv | 42 ++++
 rtl/region_mpu.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mpu_pkg.sv
// Shared definitions for the region memory-protection unit: FSM states,
// fault-cause codes, attribute bit positions and per-region register offsets.
package mpu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    ACCESS = 3'd2,
    RESP   = 3'd3,
    FAULT  = 3'd4
  } state_t;

  localparam logic [2:0] CAUSE_NONE   = 3'd0;
  localparam logic [2:0] CAUSE_NO_HIT = 3'd1;
  localparam logic [2:0] CAUSE_PERM   = 3'd2;
  localparam logic [2:0] CAUSE_RANGE  = 3'd3;
  localparam logic [2:0] CAUSE_LOCK   = 3'd4;

  localparam int ATTR_X     = 0;
  localparam int ATTR_W     = 1;
  localparam int ATTR_R     = 2;
  localparam int ATTR_VALID = 3;
  localparam int ATTR_LOCK  = 4;

  localparam int REG_CODE_START  = 0;
  localparam int REG_CODE_END    = 1;
  localparam int REG_DATA_START  = 2;
  localparam int REG_DATA_END    = 3;
  localparam int REG_ATTR        = 4;
  localparam int REGS_PER_REGION = 5;

  // Byte-lane merge of a write into an existing 32-bit register value.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/region_match.sv
// Hit and permission compare for a single protection region.
// Fetches match the address against the code range; loads/stores need the
// issuing PC inside the code range and the address inside the data range.
module region_match
  import mpu_pkg::*;
(
  input  logic [31:0] code_start,
  input  logic [31:0] code_end,
  input  logic [31:0] data_start,
  input  logic [31:0] data_end,
  input  logic [3:0]  attr,
  input  logic        instr,
  input  logic        is_write,
  input  logic [31:0] pc,
  input  logic [31:0] addr,
  output logic        hit,
  output logic        allowed
);

  logic addr_in_code;
  logic pc_in_code;
  logic addr_in_data;

  assign addr_in_code = (addr >= code_start) && (addr <= code_end);
  assign pc_in_code   = (pc   >= code_start) && (pc   <= code_end);
  assign addr_in_data = (addr >= data_start) && (addr <= data_end);

  // Region hit and the permission bit that applies to this access type.
  always_comb begin
    if (instr) begin
      hit     = attr[ATTR_VALID] && addr_in_code;
      allowed = attr[ATTR_X];
    end else if (is_write) begin
      hit     = attr[ATTR_VALID] && pc_in_code && addr_in_data;
      allowed = attr[ATTR_W];
    end else begin
      hit     = attr[ATTR_VALID] && pc_in_code && addr_in_data;
      allowed = attr[ATTR_R];
    end
  end

endmodule

// File: rtl/region_mpu.sv
// Region-based memory protection unit between a CPU port and a 1-cycle RAM.
// Each request is latched, checked against the region registers (lowest
// index hit wins), then either performed (RAM or register window) or faulted.
// Optional feature: define REGION_MPU_LOCK_EN to make attr[4] lock a region's
// registers until reset.
module region_mpu
  import mpu_pkg::*;
#(
  parameter int          MEM_WORDS  = 1024,
  parameter int          ADDR_WIDTH = 22,
  parameter int          REGION_NUM = 8,
  parameter logic [31:0] CFG_BASE   = 32'h0000_0C00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_valid,
  input  logic                  cpu_instr,
  input  logic [31:0]           cpu_pc,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [31:0]           cpu_wdata,
  input  logic [3:0]            cpu_wstrb,
  output logic                  cpu_ready,
  output logic [31:0]           cpu_rdata,
  output logic [3:0]            mem_wen,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  mpu_irq,
  input  logic                  fault_ack,
  output logic [2:0]            fault_cause,
  output logic [31:0]           fault_addr,
  output logic [31:0]           fault_pc
);

  localparam int          NREG      = REGION_NUM * REGS_PER_REGION;
  localparam logic [31:0] CFG_END   = CFG_BASE + 32'(4 * NREG);
  localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);
`ifdef REGION_MPU_LOCK_EN
  localparam logic [31:0] ATTR_MASK = 32'h0000_001F;
`else
  localparam logic [31:0] ATTR_MASK = 32'h0000_000F;
`endif

  state_t                  state;
  logic [31:0]             cfg_regs [NREG];
  logic                    req_instr;
  logic [31:0]             req_pc;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [31:0]             req_wdata;
  logic [3:0]              req_wstrb;
  logic [31:0]             rdata_q;
  logic                    resp_from_mem;

  logic [31:0]             addr_ext;
  logic                    is_write;
  logic                    in_cfg;
  logic [31:0]             cfg_idx;
  logic [REGION_NUM-1:0]   hit;
  logic [REGION_NUM-1:0]   allowed;
  logic                    found;
  logic                    allowed_sel;
  logic                    target_locked;
  logic [31:0]             cfg_rd_val;
  logic [2:0]              cause;

  assign addr_ext = 32'(req_addr);
  assign is_write = |req_wstrb;
  assign in_cfg   = (addr_ext >= CFG_BASE) && (addr_ext < CFG_END);
  assign cfg_idx  = (addr_ext - CFG_BASE) >> 2;

  for (genvar r = 0; r < REGION_NUM; r++) begin : g_region
    region_match u_match (
      .code_start (cfg_regs[REGS_PER_REGION*r + REG_CODE_START]),
      .code_end   (cfg_regs[REGS_PER_REGION*r + REG_CODE_END]),
      .data_start (cfg_regs[REGS_PER_REGION*r + REG_DATA_START]),
      .data_end   (cfg_regs[REGS_PER_REGION*r + REG_DATA_END]),
      .attr       (cfg_regs[REGS_PER_REGION*r + REG_ATTR][3:0]),
      .instr      (req_instr),
      .is_write   (is_write),
      .pc         (req_pc),
      .addr       (addr_ext),
      .hit        (hit[r]),
      .allowed    (allowed[r])
    );
  end

  // Priority pick of the lowest hitting region, register readback and lock lookup.
  always_comb begin
    found         = 1'b0;
    allowed_sel   = 1'b0;
    target_locked = 1'b0;
    cfg_rd_val    = 32'h0000_0000;
    for (int r = 0; r < REGION_NUM; r++) begin
      if (hit[r] && !found) begin
        found       = 1'b1;
        allowed_sel = allowed[r];
      end
    end
    for (int i = 0; i < NREG; i++) begin
      if (cfg_idx == 32'(i)) begin
        cfg_rd_val = cfg_regs[i];
      end
    end
`ifdef REGION_MPU_LOCK_EN
    for (int r = 0; r < REGION_NUM; r++) begin
      if ((cfg_idx >= 32'(REGS_PER_REGION*r)) && (cfg_idx < 32'(REGS_PER_REGION*r + REGS_PER_REGION)) &&
          cfg_regs[REGS_PER_REGION*r + REG_ATTR][ATTR_LOCK]) begin
        target_locked = 1'b1;
      end
    end
`endif
  end

  // Fault classification of the latched request; range errors take precedence.
  always_comb begin
    if (!in_cfg && (addr_ext >= MEM_BYTES)) begin
      cause = CAUSE_RANGE;
    end else if (!found) begin
      cause = CAUSE_NO_HIT;
    end else if (!allowed_sel) begin
      cause = CAUSE_PERM;
    end else if (in_cfg && is_write && target_locked) begin
      cause = CAUSE_LOCK;
    end else begin
      cause = CAUSE_NONE;
    end
  end

  // RAM read data is only valid in the cycle after ACCESS, so it bypasses the register.
  assign cpu_rdata = ((state == RESP) && resp_from_mem) ? mem_rdata : rdata_q;

  // Transaction FSM with registered CPU/RAM outputs, region registers and fault capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cpu_ready     <= 1'b0;
      rdata_q       <= 32'h0000_0000;
      resp_from_mem <= 1'b0;
      mem_wen       <= 4'h0;
      mem_addr      <= '0;
      mem_wdata     <= 32'h0000_0000;
      mpu_irq       <= 1'b0;
      fault_cause   <= 3'd0;
      fault_addr    <= 32'h0000_0000;
      fault_pc      <= 32'h0000_0000;
      req_instr     <= 1'b0;
      req_pc        <= 32'h0000_0000;
      req_addr      <= '0;
      req_wdata     <= 32'h0000_0000;
      req_wstrb     <= 4'h0;
      for (int i = 0; i < NREG; i++) begin
        cfg_regs[i] <= 32'h0000_0000;
      end
      cfg_regs[REG_CODE_END] <= 32'hFFFF_FFFF;
      cfg_regs[REG_DATA_END] <= 32'hFFFF_FFFF;
      cfg_regs[REG_ATTR]     <= 32'h0000_000F;
    end else begin
      if (fault_ack) begin
        mpu_irq <= 1'b0;
      end
      case (state)
        IDLE: begin
          cpu_ready <= 1'b0;
          mem_wen   <= 4'h0;
          if (cpu_valid && !cpu_ready) begin
            req_instr <= cpu_instr;
            req_pc    <= cpu_pc;
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
            req_wstrb <= cpu_wstrb;
            state     <= CHECK;
          end else begin
            state     <= IDLE;
          end
        end
        CHECK: begin
          if (cause == CAUSE_NONE) begin
            state <= ACCESS;
            if (in_cfg) begin
              rdata_q       <= cfg_rd_val;
              resp_from_mem <= 1'b0;
              if (is_write) begin
                for (int i = 0; i < NREG; i++) begin
                  if (cfg_idx == 32'(i)) begin
                    cfg_regs[i] <= ((i % REGS_PER_REGION) == REG_ATTR)
                                 ? (strb_merge(cfg_regs[i], req_wdata, req_wstrb) & ATTR_MASK)
                                 : strb_merge(cfg_regs[i], req_wdata, req_wstrb);
                  end
                end
              end
            end else begin
              mem_addr      <= req_addr[ADDR_WIDTH-1:2];
              mem_wen       <= req_wstrb;
              mem_wdata     <= req_wdata;
              rdata_q       <= 32'h0000_0000;
              resp_from_mem <= 1'b1;
            end
          end else begin
            state         <= FAULT;
            cpu_ready     <= 1'b1;
            rdata_q       <= 32'h0000_0000;
            resp_from_mem <= 1'b0;
            mpu_irq       <= 1'b1;
            if (!mpu_irq || fault_ack) begin
              fault_cause <= cause;
              fault_addr  <= addr_ext;
              fault_pc    <= req_pc;
            end
          end
        end
        ACCESS: begin
          mem_wen   <= 4'h0;
          cpu_ready <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          cpu_ready     <= 1'b0;
          rdata_q       <= 32'h0000_0000;
          resp_from_mem <= 1'b0;
          state         <= IDLE;
        end
        FAULT: begin
          cpu_ready <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          cpu_ready <= 1'b0;
          mem_wen   <= 4'h0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
